nmix_inv: RTL and testbench
===========================

// Module: nmix_inv
// PURPOSE
//   Inverse of the bit-serial NMIX mixer: recovers X from Y and R, where
//   Y[i] = X[i]^R[i]^(X[i-1]&X[i-2])^(R[i-1]&R[i-2])^XOR_{j<i}(X[j]&R[j]).
//   Terms with a negative index are 0.
//   Bit-serial, LSB first, one bit per clock, with a start/ready/valid handshake.
//   Sits on the receive/decode side of the ECC datapath, opposite the forward mixer.
// PARAMETERS
//   WIDTH  32  word width in bits; must be >= 2
// PORTS
//   clk      in   1      clock, rising-edge
//   reset_n  in   1      asynchronous, active-low reset
//   start    in   1      request; sampled only when ready=1
//   Y        in   WIDTH  mixed word, sampled with start
//   R        in   WIDTH  key word, sampled with start
//   ready    out  1      1 in IDLE and DONE
//   busy     out  1      1 in RUN
//   valid    out  1      1 in DONE; X is the result while valid=1
//   X        out  WIDTH  recovered word
//   err      out  1      self-check mismatch; present only with NMIX_INV_SELFCHECK_EN
// BEHAVIOUR
//   Reset: the block has one clock and an asynchronous, active-low reset.
//     reset_n=0 forces state=IDLE, X=0, valid=0, busy=0, ready=1, err=0,
//     bit index=0 and all accumulators=0.
//     Asserting reset in RUN aborts the operation; partial bits are discarded.
//   FSM states: IDLE, RUN, DONE.
//     IDLE/DONE, start=1 -> RUN: latch Y and R, clear X, index, S and valid.
//     RUN, index=WIDTH-1 -> DONE at that edge.
//     RUN, other index -> RUN, index++.
//     DONE, start=0 -> DONE: X and valid are held.
//   start in RUN is ignored. It is neither queued nor does it disturb the operation.
//   Per RUN cycle i, registered at the edge:
//     X[i] <= Yl[i]^Rl[i]^(X[i-1]&X[i-2])^(Rl[i-1]&Rl[i-2])^S
//     S    <= S^(X[i]&Rl[i])   (uses the X[i] computed this cycle)
//     S is the running XOR accumulator.
//     i=0: no pair terms and S=0. i=1: no pair terms, S=X0&R0.
//   Latency: start accepted at edge k -> valid=1 after edge k+WIDTH.
//     RUN lasts exactly WIDTH cycles.
//   Back-to-back: start while in DONE begins the next op. valid drops on that edge.
//   Y and R may change freely after the accepting edge; the latched copies are used.
// CONFIGURATION
//   NMIX_INV_SELFCHECK_EN defined:
//     On entry to DONE, forward-mix the result X with Rl and compare to Yl.
//     err <= (mismatch); err holds until the next accepted start or reset.
//   NMIX_INV_SELFCHECK_EN undefined:
//     No err port, no forward mixer, no extra latency.
// STRUCTURE
//   nmix_pkg: NMIX_W=32; enum nmix_inv_state_t {IDLE,RUN,DONE}.
//   nmix_pkg also holds function nmix_fwd(x,r), a combinational forward NMIX.
//   The function is shared by this block, the self-check and the bench model.
//   One sub-module, nmix_fwd_comb: a combinational wrapper of nmix_fwd.
//   nmix_fwd_comb is instantiated only under NMIX_INV_SELFCHECK_EN.
// TESTING
//   1) Y=0x00000003, R=0xFFFFFFFF -> X=0x00000000.
//      valid exactly 32 cycles after start; busy high for 32 cycles.
//   2) Y=0x00000007, R=0x00000000 -> X=0x00000003.
//      Then start again from DONE with Y=0x00000003, R=0 -> X=0xFFFFFFFF.
//   3) Y=0xFFFFFFFE, R=0x00000001 -> X=0x00000001. Exercises S propagation to the MSB.
//   4) Pulse start with different Y/R at RUN cycle 10 -> ignored. Result is the first op's X.
//   5) Drop reset_n at RUN cycle 17 -> immediately X=0, valid=0, ready=1.
//      Then a fresh op completes correctly.
//   6) 1000 random X,R: drive Y=nmix_fwd(X,R) -> recovered X matches.
//      err=0 throughout when built with the macro.

Source files
------------

// File: rtl/nmix_pkg.sv
// Shared NMIX definitions: word width, inverse-FSM state encoding and the
// combinational forward mixer used by the self-check and the bench model.
package nmix_pkg;

    localparam int unsigned NMIX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nmix_inv_state_t;

    // Forward NMIX: y[i] = x[i]^r[i]^(x[i-1]&x[i-2])^(r[i-1]&r[i-2])^XOR_{j<i}(x[j]&r[j])
    function automatic logic [NMIX_W-1:0] nmix_fwd(input logic [NMIX_W-1:0] x,
                                                   input logic [NMIX_W-1:0] r);
        logic [NMIX_W-1:0] y;
        logic s;
        logic xp1;
        logic xp2;
        logic rp1;
        logic rp2;
        y   = '0;
        s   = 1'b0;
        xp1 = 1'b0;
        xp2 = 1'b0;
        rp1 = 1'b0;
        rp2 = 1'b0;
        for (int unsigned i = 0; i < NMIX_W; i++) begin
            y[i] = x[i] ^ r[i] ^ (xp1 & xp2) ^ (rp1 & rp2) ^ s;
            s    = s ^ (x[i] & r[i]);
            xp2  = xp1;
            xp1  = x[i];
            rp2  = rp1;
            rp1  = r[i];
        end
        return y;
    endfunction

endpackage

// File: rtl/nmix_fwd_comb.sv
// Combinational forward NMIX of a W-bit word (W <= NMIX_W); zero-extension is
// safe because every output bit depends only on lower-or-equal input bits.
module nmix_fwd_comb
    import nmix_pkg::*;
#(
    parameter int unsigned W = NMIX_W
)(
    input  logic [W-1:0] x,
    input  logic [W-1:0] r,
    output logic [W-1:0] y
);

    assign y = W'(nmix_fwd(NMIX_W'(x), NMIX_W'(r)));

endmodule

// File: rtl/nmix_inv.sv
// Bit-serial NMIX inverse: recovers X from mixed word Y and key R, LSB first,
// one bit per clock. Optional result self-check under NMIX_INV_SELFCHECK_EN.
module nmix_inv
    import nmix_pkg::*;
#(
    parameter int unsigned WIDTH = NMIX_W
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] R,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] X
`ifdef NMIX_INV_SELFCHECK_EN
    ,
    output logic             err
`endif
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    nmix_inv_state_t  state;
    nmix_inv_state_t  state_d;
    logic             ready_d;
    logic             busy_d;
    logic             valid_d;

    logic [WIDTH-1:0] yl;
    logic [WIDTH-1:0] rl;
    logic [IDX_W-1:0] idx;
    logic             s;
    logic             xp1;
    logic             xp2;
    logic             rp1;
    logic             rp2;

    logic             accept_c;
    logic             run_c;
    logic             last_c;
    logic             bit_c;
    logic [WIDTH-1:0] x_next_c;

    assign accept_c = ready & start;
    assign run_c    = (state == RUN);
    assign last_c   = run_c & (idx == IDX_LAST);
    assign bit_c    = yl[idx] ^ rl[idx] ^ (xp1 & xp2) ^ (rp1 & rp2) ^ s;
    assign x_next_c = {bit_c, X[WIDTH-1:1]};

    // Next-state and next-output decode; start while running is ignored
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE, DONE: if (start) state_d = RUN;
            RUN:        if (idx == IDX_LAST) state_d = DONE;
            default:    state_d = IDLE;
        endcase
        ready_d = (state_d != RUN);
        busy_d  = (state_d == RUN);
        valid_d = (state_d == DONE);
    end

    // State and handshake output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            state <= state_d;
            ready <= ready_d;
            busy  <= busy_d;
            valid <= valid_d;
        end
    end

    // Operand latch and per-bit recovery; X shifts in from the MSB so bit 0
    // lands at the LSB after WIDTH cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            yl  <= '0;
            rl  <= '0;
            X   <= '0;
            idx <= '0;
            s   <= 1'b0;
            xp1 <= 1'b0;
            xp2 <= 1'b0;
            rp1 <= 1'b0;
            rp2 <= 1'b0;
        end else if (accept_c) begin
            yl  <= Y;
            rl  <= R;
            X   <= '0;
            idx <= '0;
            s   <= 1'b0;
            xp1 <= 1'b0;
            xp2 <= 1'b0;
            rp1 <= 1'b0;
            rp2 <= 1'b0;
        end else if (run_c) begin
            X   <= x_next_c;
            s   <= s ^ (bit_c & rl[idx]);
            xp2 <= xp1;
            xp1 <= bit_c;
            rp2 <= rp1;
            rp1 <= rl[idx];
            if (idx != IDX_LAST) idx <= idx + IDX_W'(1);
        end
    end

`ifdef NMIX_INV_SELFCHECK_EN
    logic [WIDTH-1:0] y_fwd_c;

    nmix_fwd_comb #(.W(WIDTH)) u_fwd (
        .x (x_next_c),
        .r (rl),
        .y (y_fwd_c)
    );

    // Re-mix the final result on entry to DONE and flag any disagreement
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (accept_c) begin
            err <= 1'b0;
        end else if (last_c) begin
            err <= (y_fwd_c != yl);
        end
    end
`else
    logic unused_c;
    assign unused_c = last_c;
`endif

endmodule

// File: tb/tb_nmix_inv.sv
// Directed and random checks of the bit-serial NMIX inverse.
// Build with NMIX_INV_SELFCHECK_EN to also exercise the err output.
module tb_nmix_inv;
    import nmix_pkg::*;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] Y;
    logic [W-1:0] R;
    logic         ready;
    logic         busy;
    logic         valid;
    logic [W-1:0] X;
`ifdef NMIX_INV_SELFCHECK_EN
    logic         err;
`endif

    int tests;
    int fails;
    int cyc;
    int err_hits;

    nmix_inv #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .Y       (Y),
        .R       (R),
        .ready   (ready),
        .busy    (busy),
        .valid   (valid),
        .X       (X)
`ifdef NMIX_INV_SELFCHECK_EN
        ,
        .err     (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

`ifdef NMIX_INV_SELFCHECK_EN
    always @(negedge clk) if (err === 1'b1) err_hits <= err_hits + 1;
`endif

    // Accept one operation, wait (bounded) for valid, return result and latency
    task automatic run_op(input logic [W-1:0] y, input logic [W-1:0] r,
                          output logic [W-1:0] x, output int lat);
        int c0;
        @(negedge clk);
        Y = y; R = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        Y = $urandom; R = $urandom;
        c0 = cyc;
        while (valid !== 1'b1 && (cyc - c0) < 40) begin
            @(posedge clk); #1;
        end
        x = X;
        lat = cyc - c0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; Y = '0; R = '0;
        #12;
        tests++;
        if (X !== '0 || valid !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
            fails++;
            $display("FAIL reset: X=%h valid=%b busy=%b ready=%b, expected 0/0/0/1", X, valid, busy, ready);
        end
`ifdef NMIX_INV_SELFCHECK_EN
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL reset_err: err=%b expected 0", err); end
`endif
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_latency();
        int busy_cnt;
        int c0;
        @(negedge clk);
        Y = 32'h0000_0003; R = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c0 = cyc;
        busy_cnt = 0;
        while (valid !== 1'b1 && (cyc - c0) < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (ready !== 1'b0) begin
                tests++; fails++;
                $display("FAIL ready_in_run: ready=%b expected 0 at cycle %0d", ready, cyc - c0);
            end
            @(posedge clk); #1;
        end
        tests++;
        if (cyc - c0 != 32) begin fails++; $display("FAIL t1_latency: got %0d expected 32", cyc - c0); end
        tests++;
        if (busy_cnt != 32) begin fails++; $display("FAIL t1_busy_cycles: got %0d expected 32", busy_cnt); end
        tests++;
        if (X !== 32'h0000_0000) begin fails++; $display("FAIL t1_x: got %h expected 00000000", X); end
        tests++;
        if (busy !== 1'b0 || ready !== 1'b1) begin
            fails++; $display("FAIL t1_done_flags: busy=%b ready=%b expected 0/1", busy, ready);
        end
        // DONE holds X and valid while start stays low
        repeat (3) @(posedge clk); #1;
        tests++;
        if (valid !== 1'b1 || X !== 32'h0000_0000) begin
            fails++; $display("FAIL t1_hold: valid=%b X=%h expected 1/00000000", valid, X);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x;
        int lat;
        run_op(32'h0000_0007, 32'h0000_0000, x, lat);
        tests++;
        if (x !== 32'h0000_0003 || lat != 32) begin
            fails++; $display("FAIL t2_first: X=%h lat=%0d expected 00000003/32", x, lat);
        end
        @(negedge clk);
        Y = 32'h0000_0003; R = 32'h0000_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL t2_restart: valid=%b busy=%b expected 0/1", valid, busy);
        end
        repeat (32) @(posedge clk); #1;
        tests++;
        if (valid !== 1'b1 || X !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL t2_second: valid=%b X=%h expected 1/ffffffff", valid, X);
        end
    endtask

    task automatic test_msb_carry();
        logic [W-1:0] x;
        int lat;
        run_op(32'hFFFF_FFFE, 32'h0000_0001, x, lat);
        tests++;
        if (x !== 32'h0000_0001 || lat != 32) begin
            fails++; $display("FAIL t3_s_chain: X=%h lat=%0d expected 00000001/32", x, lat);
        end
    endtask

    task automatic test_start_in_run();
        int c0;
        @(negedge clk);
        Y = 32'h0000_0003; R = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c0 = cyc;
        repeat (10) @(posedge clk);
        @(negedge clk);
        Y = 32'h0000_0007; R = 32'h0000_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            fails++; $display("FAIL t4_busy_after_pulse: busy=%b valid=%b expected 1/0", busy, valid);
        end
        while (valid !== 1'b1 && (cyc - c0) < 40) begin
            @(posedge clk); #1;
        end
        tests++;
        if (X !== 32'h0000_0000 || cyc - c0 != 32) begin
            fails++; $display("FAIL t4_ignored: X=%h lat=%0d expected 00000000/32", X, cyc - c0);
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] x;
        int lat;
        @(negedge clk);
        Y = 32'h0000_0007; R = 32'h0000_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (X !== '0 || valid !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL t5_abort: X=%h valid=%b ready=%b busy=%b expected 0/0/1/0", X, valid, ready, busy);
        end
        @(negedge clk); reset_n = 1'b1;
        run_op(32'hFFFF_FFFE, 32'h0000_0001, x, lat);
        tests++;
        if (x !== 32'h0000_0001 || lat != 32) begin
            fails++; $display("FAIL t5_fresh: X=%h lat=%0d expected 00000001/32", x, lat);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] xr;
        logic [W-1:0] rr;
        logic [W-1:0] got;
        int lat;
        int bad_lat;
        bad_lat = 0;
        for (int n = 0; n < 1000; n++) begin
            xr = $urandom;
            rr = $urandom;
            run_op(nmix_fwd(xr, rr), rr, got, lat);
            if (lat != 32) bad_lat++;
            tests++;
            if (got !== xr) begin
                fails++; $display("FAIL t6_rand[%0d]: X=%h expected %h (R=%h)", n, got, xr, rr);
            end
        end
        tests++;
        if (bad_lat != 0) begin fails++; $display("FAIL t6_latency: %0d ops off 32, expected 0", bad_lat); end
`ifdef NMIX_INV_SELFCHECK_EN
        tests++;
        if (err_hits != 0) begin fails++; $display("FAIL t6_err: err high %0d cycles, expected 0", err_hits); end
`endif
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; err_hits = 0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_msb_carry();
        test_start_in_run();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
